// File: rtl/pp_wb_buf_if.sv
// Writeback request channel into the pending-write buffer.
interface pp_wb_buf_if;
   logic        wb_valid;
   logic        wb_ready;
   logic [4:0]  wb_rd;
   logic [31:0] wb_data;

   modport master (output wb_valid, output wb_rd, output wb_data, input wb_ready);
   modport slave  (input wb_valid, input wb_rd, input wb_data, output wb_ready);
endinterface

// File: rtl/pp_wb_buf.sv
// Pending-write buffer between writeback and the register file, with operand correction.
// Optional macro PP_WB_BUF_FWD_EN enables newest-match operand forwarding.
module pp_wb_buf #(
   parameter int unsigned DEPTH = 2
) (
   input  logic                     clk,
   input  logic                     rst,
   pp_wb_buf_if.slave               wb,
   input  logic                     drain_en,
   input  logic [4:0]               rs1,
   input  logic [4:0]               rs2,
   input  logic [31:0]              rf_rd1,
   input  logic [31:0]              rf_rd2,
   output logic [4:0]               rd,
   output logic [31:0]              writedata,
   output logic                     regwrite,
   output logic [31:0]              op1,
   output logic [31:0]              op2,
   output logic                     hazard,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int unsigned PtrW = $clog2(DEPTH);
   localparam int unsigned CntW = PtrW + 1;

   logic [4:0]      rd_mem   [DEPTH];
   logic [31:0]     data_mem [DEPTH];
   logic [PtrW-1:0] head_q, head_d;
   logic [PtrW-1:0] tail_q, tail_d;
   logic [CntW-1:0] count_q, count_d;
   logic            not_empty;
   logic            push;
   logic            pop;
   logic            hit1;
   logic            hit2;
   logic [PtrW-1:0] idx;
   logic [31:0]     fwd1;
   logic [31:0]     fwd2;

   assign not_empty   = (count_q != '0);
   assign regwrite    = not_empty & drain_en;
   assign pop         = regwrite;
   assign wb.wb_ready = (count_q < CntW'(DEPTH)) | regwrite;
   // Writes to x0 complete the handshake but are never buffered.
   assign push        = wb.wb_valid & wb.wb_ready & (wb.wb_rd != 5'd0);
   assign rd          = not_empty ? rd_mem[head_q]   : 5'd0;
   assign writedata   = not_empty ? data_mem[head_q] : 32'd0;
   assign count       = count_q;

   always_comb begin
      head_d  = head_q;
      tail_d  = tail_q;
      count_d = count_q;
      if (pop) begin
         head_d = head_q + PtrW'(1);
      end
      if (push) begin
         tail_d = tail_q + PtrW'(1);
      end
      unique case ({push, pop})
         2'b10:   count_d = count_q + CntW'(1);
         2'b01:   count_d = count_q - CntW'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         rd_mem[tail_q]   <= wb.wb_rd;
         data_mem[tail_q] <= wb.wb_data;
      end
   end

   // Walk oldest to newest so a later match overrides an earlier one.
   always_comb begin
      hit1 = 1'b0;
      hit2 = 1'b0;
      fwd1 = rf_rd1;
      fwd2 = rf_rd2;
      idx  = head_q;
      for (int unsigned i = 0; i < DEPTH; i++) begin
         idx = head_q + PtrW'(i);
         if (CntW'(i) < count_q) begin
            if ((rs1 != 5'd0) && (rd_mem[idx] == rs1)) begin
               hit1 = 1'b1;
`ifdef PP_WB_BUF_FWD_EN
               fwd1 = data_mem[idx];
`endif
            end
            if ((rs2 != 5'd0) && (rd_mem[idx] == rs2)) begin
               hit2 = 1'b1;
`ifdef PP_WB_BUF_FWD_EN
               fwd2 = data_mem[idx];
`endif
            end
         end
      end
   end

   assign hazard = hit1 | hit2;

`ifdef PP_WB_BUF_FWD_EN
   assign op1 = fwd1;
   assign op2 = fwd2;
`else
   assign op1 = rf_rd1;
   assign op2 = rf_rd2;
   logic unused_fwd;
   assign unused_fwd = ^{fwd1, fwd2};
`endif

endmodule

// File: tb/tb_pp_wb_buf.sv
// Directed self-checking bench for pp_wb_buf (DEPTH=2), with or without forwarding.
module tb_pp_wb_buf;
   localparam int unsigned DEPTH = 2;
   localparam int unsigned CntW  = $clog2(DEPTH) + 1;

   logic            clk = 1'b0;
   logic            rst;
   logic            drain_en;
   logic [4:0]      rs1, rs2;
   logic [31:0]     rf_rd1, rf_rd2;
   logic [4:0]      rd;
   logic [31:0]     writedata;
   logic            regwrite;
   logic [31:0]     op1, op2;
   logic            hazard;
   logic [CntW-1:0] count;

   int errs   = 0;
   int checks = 0;

   logic [36:0] wlog [$];

   pp_wb_buf_if wbi ();

   pp_wb_buf #(.DEPTH(DEPTH)) dut (
      .clk       (clk),
      .rst       (rst),
      .wb        (wbi),
      .drain_en  (drain_en),
      .rs1       (rs1),
      .rs2       (rs2),
      .rf_rd1    (rf_rd1),
      .rf_rd2    (rf_rd2),
      .rd        (rd),
      .writedata (writedata),
      .regwrite  (regwrite),
      .op1       (op1),
      .op2       (op2),
      .hazard    (hazard),
      .count     (count)
   );

   always #5 clk = ~clk;

   // Register-file model: record every write the file would capture.
   always @(posedge clk) begin
      if (regwrite === 1'b1) wlog.push_back({rd, writedata});
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      #3;
      checks++; if (count !== 0) begin errs++; $display("FAIL rst_count got %0d want 0", count); end
      checks++; if (regwrite !== 1'b0) begin errs++; $display("FAIL rst_regwrite got %b want 0", regwrite); end
      checks++; if (rd !== 5'd0) begin errs++; $display("FAIL rst_rd got %0d want 0", rd); end
      checks++; if (writedata !== 32'd0) begin errs++; $display("FAIL rst_wdata got %h want 0", writedata); end
      checks++; if (hazard !== 1'b0) begin errs++; $display("FAIL rst_hazard got %b want 0", hazard); end
      checks++; if (wbi.wb_ready !== 1'b1) begin errs++; $display("FAIL rst_ready got %b want 1", wbi.wb_ready); end
      tick();
      rst = 1'b0;
   endtask

   task automatic test_single();
      drain_en = 1'b1;
      wbi.wb_valid = 1'b1; wbi.wb_rd = 5'd5; wbi.wb_data = 32'hA5A5_0001;
      #1;
      checks++; if (wbi.wb_ready !== 1'b1) begin errs++; $display("FAIL single_ready got %b want 1", wbi.wb_ready); end
      tick();
      wbi.wb_valid = 1'b0;
      #1;
      checks++; if (regwrite !== 1'b1) begin errs++; $display("FAIL single_regwrite got %b want 1", regwrite); end
      checks++; if (rd !== 5'd5) begin errs++; $display("FAIL single_rd got %0d want 5", rd); end
      checks++; if (writedata !== 32'hA5A5_0001) begin errs++; $display("FAIL single_wdata got %h want a5a50001", writedata); end
      checks++; if (count !== 1) begin errs++; $display("FAIL single_count1 got %0d want 1", count); end
      tick();
      checks++; if (count !== 0) begin errs++; $display("FAIL single_count0 got %0d want 0", count); end
      checks++; if (regwrite !== 1'b0) begin errs++; $display("FAIL single_idle got %b want 0", regwrite); end
      checks++; if (wlog.size() !== 1) begin errs++; $display("FAIL single_nwrites got %0d want 1", wlog.size()); end
      else begin
         checks++; if (wlog[0] !== {5'd5, 32'hA5A5_0001}) begin errs++; $display("FAIL single_write got %h want %h", wlog[0], {5'd5, 32'hA5A5_0001}); end
      end
      wlog.delete();
   endtask

   task automatic test_full_fwd();
      logic [31:0] exp_op1;
      drain_en = 1'b0;
      wbi.wb_valid = 1'b1; wbi.wb_rd = 5'd3; wbi.wb_data = 32'h11;
      tick();
      wbi.wb_data = 32'h22;
      tick();
      wbi.wb_valid = 1'b0;
      rs1 = 5'd3; rf_rd1 = 32'hCAFE_0001;
      rs2 = 5'd5; rf_rd2 = 32'hBEEF_0002;
      #1;
`ifdef PP_WB_BUF_FWD_EN
      exp_op1 = 32'h22;
`else
      exp_op1 = 32'hCAFE_0001;
`endif
      checks++; if (count !== 2) begin errs++; $display("FAIL full_count got %0d want 2", count); end
      checks++; if (wbi.wb_ready !== 1'b0) begin errs++; $display("FAIL full_ready got %b want 0", wbi.wb_ready); end
      checks++; if (op1 !== exp_op1) begin errs++; $display("FAIL full_op1 got %h want %h", op1, exp_op1); end
      checks++; if (hazard !== 1'b1) begin errs++; $display("FAIL full_hazard got %b want 1", hazard); end
      checks++; if (op2 !== 32'hBEEF_0002) begin errs++; $display("FAIL full_op2 got %h want beef0002", op2); end
      checks++; if (regwrite !== 1'b0) begin errs++; $display("FAIL full_regwrite got %b want 0", regwrite); end
      rs1 = 5'd0;
      #1;
      checks++; if (hazard !== 1'b0) begin errs++; $display("FAIL full_nohazard got %b want 0", hazard); end
      checks++; if (op1 !== 32'hCAFE_0001) begin errs++; $display("FAIL full_rs0 got %h want cafe0001", op1); end
   endtask

   task automatic test_push_pop_full();
      logic [36:0] exp_w [3];
      logic [31:0] exp_op1;
      exp_w[0] = {5'd3, 32'h11};
      exp_w[1] = {5'd3, 32'h22};
      exp_w[2] = {5'd7, 32'h77};
      drain_en = 1'b1;
      wbi.wb_valid = 1'b1; wbi.wb_rd = 5'd7; wbi.wb_data = 32'h77;
      #1;
      checks++; if (wbi.wb_ready !== 1'b1) begin errs++; $display("FAIL pp_ready got %b want 1", wbi.wb_ready); end
      checks++; if (writedata !== 32'h11) begin errs++; $display("FAIL pp_head0 got %h want 11", writedata); end
      tick();
      wbi.wb_valid = 1'b0;
      rs1 = 5'd7; rf_rd1 = 32'h0BAD_0007;
      #1;
`ifdef PP_WB_BUF_FWD_EN
      exp_op1 = 32'h77;
`else
      exp_op1 = 32'h0BAD_0007;
`endif
      checks++; if (count !== 2) begin errs++; $display("FAIL pp_count got %0d want 2", count); end
      checks++; if (writedata !== 32'h22) begin errs++; $display("FAIL pp_head1 got %h want 22", writedata); end
      checks++; if (op1 !== exp_op1) begin errs++; $display("FAIL pp_op1_wrap got %h want %h", op1, exp_op1); end
      checks++; if (hazard !== 1'b1) begin errs++; $display("FAIL pp_hazard got %b want 1", hazard); end
      tick();
      tick();
      checks++; if (count !== 0) begin errs++; $display("FAIL pp_drained got %0d want 0", count); end
      checks++; if (wlog.size() !== 3) begin errs++; $display("FAIL pp_nwrites got %0d want 3", wlog.size()); end
      else begin
         for (int i = 0; i < 3; i++) begin
            checks++;
            if (wlog[i] !== exp_w[i]) begin
               errs++; $display("FAIL pp_order[%0d] got %h want %h", i, wlog[i], exp_w[i]);
            end
         end
      end
      wlog.delete();
   endtask

   task automatic test_rd_zero();
      drain_en = 1'b1;
      wbi.wb_valid = 1'b1; wbi.wb_rd = 5'd0; wbi.wb_data = 32'hDEAD;
      rs1 = 5'd0; rf_rd1 = 32'h1234_5678;
      #1;
      checks++; if (wbi.wb_ready !== 1'b1) begin errs++; $display("FAIL x0_ready got %b want 1", wbi.wb_ready); end
      checks++; if (op1 !== 32'h1234_5678) begin errs++; $display("FAIL x0_op1 got %h want 12345678", op1); end
      tick();
      wbi.wb_valid = 1'b0;
      #1;
      checks++; if (count !== 0) begin errs++; $display("FAIL x0_count got %0d want 0", count); end
      checks++; if (regwrite !== 1'b0) begin errs++; $display("FAIL x0_regwrite got %b want 0", regwrite); end
      tick();
      tick();
      checks++; if (wlog.size() !== 0) begin errs++; $display("FAIL x0_nwrites got %0d want 0", wlog.size()); end
      wlog.delete();
   endtask

   task automatic test_reset_mid();
      drain_en = 1'b0;
      wbi.wb_valid = 1'b1; wbi.wb_rd = 5'd9; wbi.wb_data = 32'h99;
      tick();
      wbi.wb_rd = 5'd10; wbi.wb_data = 32'hAA;
      tick();
      wbi.wb_valid = 1'b0;
      rs1 = 5'd9;
      #1;
      checks++; if (count !== 2) begin errs++; $display("FAIL rm_count2 got %0d want 2", count); end
      drain_en = 1'b1;
      rst = 1'b1;
      wbi.wb_valid = 1'b1; wbi.wb_rd = 5'd11; wbi.wb_data = 32'hBB;
      #1;
      checks++; if (count !== 0) begin errs++; $display("FAIL rm_count0 got %0d want 0", count); end
      checks++; if (regwrite !== 1'b0) begin errs++; $display("FAIL rm_regwrite got %b want 0", regwrite); end
      checks++; if (hazard !== 1'b0) begin errs++; $display("FAIL rm_hazard got %b want 0", hazard); end
      checks++; if (wbi.wb_ready !== 1'b1) begin errs++; $display("FAIL rm_ready got %b want 1", wbi.wb_ready); end
      tick();
      rst = 1'b0;
      wbi.wb_valid = 1'b0;
      tick();
      tick();
      tick();
      checks++; if (count !== 0) begin errs++; $display("FAIL rm_after_count got %0d want 0", count); end
      checks++; if (wlog.size() !== 0) begin errs++; $display("FAIL rm_nwrites got %0d want 0", wlog.size()); end
   endtask

   initial begin
      rst = 1'b1;
      drain_en = 1'b0;
      rs1 = 5'd0; rs2 = 5'd0;
      rf_rd1 = 32'd0; rf_rd2 = 32'd0;
      wbi.wb_valid = 1'b0; wbi.wb_rd = 5'd0; wbi.wb_data = 32'd0;
      test_reset();
      test_single();
      test_full_fwd();
      test_push_pop_full();
      test_rd_zero();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end
endmodule
